// File: rtl/ksz_bus_reader.sv
// KSZ8851 host-bus read engine: one command cycle, then one or more RDN data strobes.
// Outputs are registered from the current state, so they trail the state register by one cycle.
module ksz_bus_reader #(
   parameter int STROBE_CYCLES = 2,
   parameter int RECOV_CYCLES  = 1,
   parameter int LEN_W         = 11
) (
   input  logic             clk40m,
   input  logic             reset,
   input  logic             rd_req,
   input  logic [7:0]       rd_addr,
   input  logic [3:0]       rd_be,
   input  logic [LEN_W-1:0] rd_len,
   input  logic             bus_gnt,
   input  logic [15:0]      sd_in,
   output logic             bus_req,
   output logic [15:0]      sd_out,
   output logic             sd_oe,
   output logic             cmd,
   output logic             rdn,
   output logic             wrn,
   output logic [15:0]      rd_data,
   output logic             rd_valid,
   output logic             rd_done,
   output logic             busy
);

   localparam int TMR_MAX = (STROBE_CYCLES > RECOV_CYCLES) ? STROBE_CYCLES : RECOV_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] STROBE_LAST = TMR_W'(STROBE_CYCLES - 1);
   localparam logic [TMR_W-1:0] RECOV_LAST  = TMR_W'(RECOV_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_GNT,
      S_CMD,
      S_CMD_HOLD,
      S_TURN,
      S_RD,
      S_RECOV
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         addr_q;
   logic [3:0]         be_q;
   logic               accept;
   logic               drive_cmd;
   logic               word_cap;
   logic               last_word;
   logic [15:0]        cmd_word;

   assign cmd_word  = {be_q, 4'b0000, addr_q};
   assign drive_cmd = (state_q == S_CMD) || (state_q == S_CMD_HOLD);
   assign word_cap  = (state_q == S_RECOV) && (tmr_q == '0);
   assign last_word = (cnt_q <= LEN_W'(1));

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (rd_req) begin
               accept  = 1'b1;
               cnt_d   = (rd_len == '0) ? LEN_W'(1) : rd_len;
               state_d = bus_gnt ? S_CMD : S_WAIT_GNT;
            end
         end
         S_WAIT_GNT: begin
            if (bus_gnt) state_d = S_CMD;
         end
         S_CMD: begin
            if (tmr_q == STROBE_LAST) begin
               tmr_d   = '0;
               state_d = S_CMD_HOLD;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_CMD_HOLD: state_d = S_TURN;
         S_TURN:     state_d = S_RD;
         S_RD: begin
            if (tmr_q == STROBE_LAST) begin
               tmr_d   = '0;
               state_d = S_RECOV;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_RECOV: begin
            // The count is only decremented when leaving RECOV, so last_word stays stable for rd_done.
            if (last_word) begin
               tmr_d   = '0;
               state_d = S_IDLE;
            end else if (tmr_q == RECOV_LAST) begin
               tmr_d   = '0;
               cnt_d   = cnt_q - LEN_W'(1);
               state_d = S_RD;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk40m or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q <= rd_addr & 8'hFC;
            be_q   <= rd_be;
         end
      end
   end

   always_ff @(posedge clk40m or negedge reset) begin
      if (!reset) begin
         bus_req  <= 1'b0;
         sd_out   <= '0;
         sd_oe    <= 1'b0;
         cmd      <= 1'b0;
         rdn      <= 1'b1;
         wrn      <= 1'b1;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_done  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         bus_req  <= (state_d != S_IDLE);
         busy     <= (state_q != S_IDLE);
         cmd      <= drive_cmd;
         sd_oe    <= drive_cmd;
         sd_out   <= drive_cmd ? cmd_word : '0;
         wrn      <= (state_q != S_CMD);
         rdn      <= (state_q != S_RD);
         rd_valid <= word_cap;
         rd_done  <= word_cap && last_word;
         if (word_cap) rd_data <= sd_in;
      end
   end

endmodule

// File: doc/ksz_bus_reader.md
# ksz_bus_reader

Host-bus read engine for the KSZ8851 Ethernet controller, complementing the register-write initialization sequencer. It issues one command (address) cycle on the 16-bit host bus, then performs one or more data read strobes, returning each word with a one-cycle valid pulse. Single reads serve register polling (ISR, RXFCTR); burst reads drain the RX QMU data port. The top level arbitrates SD, CMD, RDN and WRN between this block and the write sequencer through `bus_req`/`bus_gnt`.

## Interface
- `STROBE_CYCLES`, 2: width of the WRN/RDN low pulse, in clk40m cycles (50 ns).
- `RECOV_CYCLES`, 1: minimum RDN-high time between consecutive data reads.
- `LEN_W`, 11: width of the burst length.

- `clk40m`  in  1  40 MHz system clock.
- `reset`  in  1  Asynchronous, active-low reset.
- `rd_req`  in  1  Start request; sampled only in IDLE.
- `rd_addr`  in  8  Register byte address; bits [1:0] are ignored.
- `rd_be`  in  4  Byte enables placed in the command word.
- `rd_len`  in  LEN_W  Number of data words to read; 0 is treated as 1.
- `bus_gnt`  in  1  Bus granted by the top-level arbiter.
- `sd_in`  in  16  SD pins, input path.
- `bus_req`  out  1  Request for the host bus.
- `sd_out`  out  16  SD drive value.
- `sd_oe`  out  1  SD output enable.
- `cmd`  out  1  KSZ CMD pin (1 = command cycle).
- `rdn`  out  1  KSZ RDN pin.
- `wrn`  out  1  KSZ WRN pin.
- `rd_data`  out  16  Last word read.
- `rd_valid`  out  1  One-cycle pulse per word.
- `rd_done`  out  1  One-cycle pulse, coincident with the last `rd_valid`.
- `busy`  out  1  High from the cycle after acceptance through the cycle of `rd_done`.

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset values.** `bus_req`=0, `sd_out`=0, `sd_oe`=0, `cmd`=0, `rdn`=1, `wrn`=1, `rd_data`=0, `rd_valid`=0, `rd_done`=0, `busy`=0.
- **Command word.** `{rd_be[3:0], 4'b0000, rd_addr[7:2], 2'b00}`.
- **Latching.** `rd_addr`, `rd_be` and `rd_len` are latched on acceptance. Changes to them while busy are ignored.
- **States.**
  - IDLE: if `rd_req`, latch inputs and assert `bus_req`. Go to CMD if `bus_gnt`=1 in the same cycle, otherwise go to WAIT_GNT.
  - WAIT_GNT: hold `bus_req`=1. Go to CMD when `bus_gnt`=1.
  - CMD: `cmd`=1, `sd_oe`=1, `sd_out`=command word, `wrn`=0 for STROBE_CYCLES cycles. Then go to CMD_HOLD.
  - CMD_HOLD (1 cycle): `wrn`=1; `cmd`, `sd_oe` and `sd_out` unchanged.
  - TURN (1 cycle): `sd_oe`=0, `cmd`=0.
  - RD: `rdn`=0 for STROBE_CYCLES cycles. `sd_in` is captured into `rd_data` on the final low cycle.
  - RECOV: `rdn`=1 and `rd_valid` pulses on the first RECOV cycle.
    - If the remaining word count is >1, decrement it and return to RD after RECOV_CYCLES cycles.
    - Otherwise pulse `rd_done` together with `rd_valid`, drop `bus_req`, and go to IDLE.
- **Word count.** Remaining count is LEN_W bits. Each RD→RECOV pass decrements it; 0 loads as 1.
- **Burst reads.** Only one command cycle is issued per request. No command is re-issued between data words.
- **Grant loss.** If `bus_gnt` falls after CMD has started, the transaction completes anyway. The arbiter must not revoke grant while `bus_req`=1.
- **Reset mid-operation.** All outputs return to their reset values immediately (asynchronous), with `sd_oe`=0 and strobes high. No partial `rd_valid` is produced.
- **Back-to-back requests.** `rd_req` held high at `rd_done` is accepted one cycle later, from IDLE.

## Timing
- Times below are relative to acceptance edge E0 (IDLE with `rd_req`=1 and `bus_gnt`=1), with default parameters.
- **Command cycle.**
  - `cmd`=1, `sd_oe`=1, `wrn`=0 in cycles 1–2.
  - `wrn`=1 in cycle 3, with data still driven (hold).
  - `sd_oe`=0 and `cmd`=0 in cycle 4.
- **First word.** `rdn`=0 in cycles 5–6; `rd_valid` and `rdn`=1 in cycle 7.
- **First-word latency formula.** 2·STROBE_CYCLES+3 cycles.
- **Burst spacing.** Subsequent words arrive every STROBE_CYCLES+RECOV_CYCLES cycles (3 with defaults).
- **Burst duration.** The last word of an N-word burst arrives at cycle 7+3·(N−1).
- **Grant wait.** Each cycle spent in WAIT_GNT adds one cycle of latency.
- **Bus contention.** `sd_oe` is never high while `rdn`=0; TURN guarantees at least 1 cycle between them.

## Test plan
- **Reset values.** Assert `reset`=0 → all outputs at reset values, `rdn`=`wrn`=1, `sd_oe`=0.
- **Single read.** Request `rd_addr`=0x92, `rd_be`=0x3, `rd_len`=1, `bus_gnt`=1; model returns 0xA5C3.
  - `sd_out`=0x3090 with `cmd`=1 in cycles 1–3.
  - `wrn` low in cycles 1–2 only.
  - `rd_valid`, `rd_done` and `rd_data`=0xA5C3 at cycle 7; `busy` low at cycle 8.
- **Burst read.** `rd_len`=4, model returns 0x0001..0x0004.
  - Exactly one `cmd`=1 phase.
  - `rd_valid` at cycles 7, 10, 13, 16 carrying words in order.
  - `rd_done` only at cycle 16.
- **Delayed grant.** `bus_gnt` held 0 for 5 cycles after `rd_req` → `bus_req`=1 throughout, no strobe activity, `rd_valid` at 7+5.
- **Reset mid-burst.** `reset` pulsed low during the second RD of `rd_len`=4 → strobes high, `sd_oe`=0 immediately. A new request afterwards completes normally.
- **Edge-case lengths.** `rd_len`=0 → exactly one word read. `rd_len`=2047 → 2047 `rd_valid` pulses, the counter does not wrap.
